w_sram_ctrl: RTL and testbench

W_SRAM_CTRL -- requirements
Module: w_sram_ctrl

---
 rtl/w_sram_ctrl.sv | 137 +++++++++++++
 tb/tb_w_sram_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_sram_ctrl.sv
// rtl/w_sram_ctrl.sv - weight SRAM controller: host writes and burst reads (optional W_SRAM_CTRL_WRAP_EN)
module w_sram_ctrl #(
  parameter int DEPTH = 108,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          rd_start,
  input  logic [AW-1:0] rd_base,
  input  logic [AW-1:0] rd_len,
  output logic          rd_busy,
  output logic          rd_valid,
  output logic          rd_done,
  output logic [DW-1:0] rd_data,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q,
  output logic          err_oob
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] addr_nxt;
  logic          rd_valid_q;
  logic          rd_done_q;
  logic          err_oob_q;
  logic          base_ok;
  logic          range_ok;
  logic          wr_in_range;

  assign base_ok     = {1'b0, rd_base} < DEPTH_W;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;

`ifdef W_SRAM_CTRL_WRAP_EN
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

  // Any length is legal once the base is inside the array; the pointer wraps.
  assign range_ok = base_ok;
  assign addr_nxt = (addr_q == LAST_A) ? '0 : addr_q + 1'b1;
`else
  logic [AW:0] rd_end;

  // Without wrapping the whole burst must fit below DEPTH.
  assign rd_end   = {1'b0, rd_base} + {1'b0, rd_len};
  assign range_ok = base_ok && (rd_end <= DEPTH_W);
  assign addr_nxt = addr_q + 1'b1;
`endif

  assign rd_busy  = (state == BURST) || (state == DRAIN);
  assign rd_valid = rd_valid_q;
  assign rd_done  = rd_done_q;
  assign err_oob  = err_oob_q;
  assign rd_data  = sram_q;

  // Write grant and SRAM port mux; a read start in IDLE wins over a write.
  always_comb begin
    wr_gnt   = 1'b0;
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (!reset) begin
      wr_gnt = wr_req && ((state == IDLE) || (state == DRAIN)) &&
               !((state == IDLE) && rd_start);
      if (state == BURST) begin
        sram_cen = 1'b0;
        sram_a   = addr_q;
      end else if (wr_gnt && wr_in_range) begin
        sram_cen = 1'b0;
        sram_wen = 1'b0;
        sram_a   = wr_addr;
        sram_d   = wr_data;
      end
    end
  end

  // Burst FSM with registered valid/done and the sticky range error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      err_oob_q  <= 1'b0;
    end else begin
      rd_valid_q <= (state == BURST);
      rd_done_q  <= 1'b0;
      if (wr_gnt && !wr_in_range) begin
        err_oob_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (rd_start) begin
            if ((rd_len != '0) && range_ok) begin
              state  <= BURST;
              addr_q <= rd_base;
              cnt_q  <= rd_len;
            end else begin
              rd_done_q <= 1'b1;
              if (!range_ok) begin
                err_oob_q <= 1'b1;
              end
            end
          end
        end
        BURST: begin
          addr_q <= addr_nxt;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == AW'(1)) begin
            state     <= DRAIN;
            rd_done_q <= 1'b1;
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w_sram_ctrl.sv
// tb/tb_w_sram_ctrl.sv - self-checking bench for w_sram_ctrl
module tb_w_sram_ctrl;

  localparam int DEPTH = 108;
  localparam int AW    = 7;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] rd_len;
  logic          rd_busy;
  logic          rd_valid;
  logic          rd_done;
  logic [DW-1:0] rd_data;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;
  logic          err_oob;

  w_sram_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_done(rd_done), .rd_data(rd_data),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  // behavioural SRAM, one-cycle read latency
  logic [DW-1:0] mem [0:127];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      else           sram_q <= mem[sram_a];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] exp_q[$];
  int            ea_q[$];

  int v_cnt, v_first, v_last, d_cnt, d_cyc, r_cnt, w_cnt;
  bit busy_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (rd_valid) begin
      v_cnt++;
      if (v_first < 0) v_first = cyc;
      v_last = cyc;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 at cycle %0d expected none", cyc);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
    if (rd_done) begin
      d_cnt++;
      d_cyc = cyc;
    end
    if (rd_busy) busy_seen = 1'b1;
    if (!sram_cen && sram_wen) begin
      r_cnt++;
      if (ea_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sram_read_unexpected: got read of %0d at cycle %0d expected none", sram_a, cyc);
      end else begin
        chk("sram_a_read", 32'(sram_a), 32'(ea_q.pop_front()));
      end
    end
    if (!sram_cen && !sram_wen) w_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    v_cnt = 0; v_first = -1; v_last = -1; d_cnt = 0; d_cyc = -1;
    r_cnt = 0; w_cnt = 0; busy_seen = 1'b0;
  endtask

  task automatic expect_burst(input int base, input int len);
    for (int k = 0; k < len; k++) begin
      int a;
      a = base + k;
      if (a >= DEPTH) a = a - DEPTH;
      ea_q.push_back(a);
      exp_q.push_back(ref_mem[a]);
    end
  endtask

  task automatic start_rd(input int base, input int len, output int n);
    n = cyc;
    rd_base  = AW'(base);
    rd_len   = AW'(len);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    wr_req  = 1'b1;
    wr_addr = 7'd3;
    wr_data = 32'h5555_AAAA;
    #1;
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_sram_cen", sram_cen, 1);
    chk("rst_sram_d", sram_d, 0);
    tick();
    tick();
    reset  = 1'b0;
    wr_req = 1'b0;
    #1;
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_err_oob", err_oob, 0);
  endtask

  task automatic burst_check(input string tag, input int base, input int len);
    int n;
    clr_mon();
    expect_burst(base, len);
    start_rd(base, len, n);
    repeat (len + 4) tick();
    chk({tag, "_first_valid"}, v_first, n + 2);
    chk({tag, "_valid_count"}, v_cnt, len);
    chk({tag, "_last_valid"}, v_last, n + len + 1);
    chk({tag, "_done_count"}, d_cnt, 1);
    chk({tag, "_done_cycle"}, d_cyc, n + len + 1);
    chk({tag, "_scoreboard_empty"}, exp_q.size() + ea_q.size(), 0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_gnt;
    logic          exp_cen;
    logic          exp_wen;
  } wvec_t;

  wvec_t wtab[16];

  initial begin
    int n;
    int gcyc;

    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int gcyc;

    for (int i = 0; i < 128; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      wtab[i]     = '{AW'(i), 32'hA5A5_0000 + 32'(i), 1'b1, 1'b0, 1'b0};
      wtab[i + 8] = '{AW'(100 + i), 32'hC0DE_0000 + 32'(i), 1'b1, 1'b0, 1'b0};
    end
    rd_start = 1'b0; rd_base = '0; rd_len = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    clr_mon();

    apply_reset();
    chk("idle_sram_cen", sram_cen, 1);
    chk("idle_sram_a", 32'(sram_a), 0);

    // table-driven writes
    for (int i = 0; i < 16; i++) begin
      wr_req  = 1'b1;
      wr_addr = wtab[i].addr;
      wr_data = wtab[i].data;
      #1;
      chk("wr_gnt", wr_gnt, wtab[i].exp_gnt);
      chk("wr_sram_cen", sram_cen, wtab[i].exp_cen);
      chk("wr_sram_wen", sram_wen, wtab[i].exp_wen);
      chk("wr_sram_a", 32'(sram_a), 32'(wtab[i].addr));
      chk("wr_sram_d", sram_d, wtab[i].data);
      ref_mem[wtab[i].addr] = wtab[i].data;
      tick();
    end
    wr_req = 1'b0;
    tick();

    burst_check("burst0_8", 0, 8);
    burst_check("burst100_8", 100, 8);
    chk("burst_err_oob", err_oob, 0);

    // read start and write in the same IDLE cycle
    clr_mon();
    expect_burst(0, 2);
    n = cyc;
    rd_base = 7'd0; rd_len = 7'd2; rd_start = 1'b1;
    wr_req = 1'b1; wr_addr = 7'd5; wr_data = 32'hDEAD_0005;
    #1;
    chk("collide_wr_gnt", wr_gnt, 0);
    tick();
    rd_start = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 6; i++) begin
      if (wr_gnt) begin
        gcyc = cyc;
        tick();
        break;
      end
      tick();
    end
    wr_req = 1'b0;
    ref_mem[5] = 32'hDEAD_0005;
    chk("collide_gnt_cycle", gcyc, n + 3);
    repeat (3) tick();
    chk("collide_valid_count", v_cnt, 2);
    chk("collide_done_count", d_cnt, 1);
    burst_check("readback5", 5, 1);

    // burst across the top of the array
`ifdef W_SRAM_CTRL_WRAP_EN
    burst_check("wrap104_8", 104, 8);
    chk("wrap_err_oob", err_oob, 0);
`else
    clr_mon();
    start_rd(104, 8, n);
    chk("oob_range_done", rd_done, 1);
    chk("oob_range_busy", rd_busy, 0);
    chk("oob_range_err", err_oob, 1);
    tick();
    chk("oob_range_done_pulse", rd_done, 0);
    repeat (4) tick();
    chk("oob_range_reads", r_cnt, 0);
    chk("oob_range_done_count", d_cnt, 1);
`endif
    apply_reset();

    // out-of-range write is granted but never reaches the SRAM
    clr_mon();
    wr_req = 1'b1; wr_addr = 7'd110; wr_data = 32'h1234_5678;
    #1;
    chk("oob_wr_gnt", wr_gnt, 1);
    chk("oob_wr_cen", sram_cen, 1);
    tick();
    wr_req = 1'b0;
    chk("oob_wr_err", err_oob, 1);
    burst_check("after_oob", 2, 3);
    chk("oob_wr_sticky", err_oob, 1);
    chk("oob_wr_no_write", w_cnt, 0);
    apply_reset();

    // reset on the third cycle of a long burst
    clr_mon();
    expect_burst(0, 2);
    start_rd(0, 10, n);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("abort_cen_in_reset", sram_cen, 1);
    tick();
    reset = 1'b0;
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_rd_busy", rd_busy, 0);
    repeat (12) tick();
    chk("abort_valid_count", v_cnt, 2);
    chk("abort_done_count", d_cnt, 0);
    chk("abort_scoreboard", exp_q.size() + ea_q.size(), 0);
    burst_check("post_abort", 0, 3);

    // zero-length read
    clr_mon();
    start_rd(3, 0, n);
    chk("len0_done", rd_done, 1);
    chk("len0_busy", rd_busy, 0);
    repeat (4) tick();
    chk("len0_done_count", d_cnt, 1);
    chk("len0_busy_seen", busy_seen, 0);
    chk("len0_reads", r_cnt, 0);
    chk("len0_err", err_oob, 0);

    // base beyond the array
    clr_mon();
    start_rd(110, 1, n);
    chk("oob_base_done", rd_done, 1);
    chk("oob_base_err", err_oob, 1);
    repeat (4) tick();
    chk("oob_base_reads", r_cnt, 0);
    chk("oob_base_busy_seen", busy_seen, 0);
    apply_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
